// File: rtl/ctrl_hazard_unit.sv
// -----------------------------------------------------------------------------
// ctrl_hazard_unit
//
// Pipeline control for a classic 5-stage in-order core. Detects read-after-
// write hazards between the instruction in ID and older instructions still in
// flight, freezes the front end (PC and IF/ID) while injecting a bubble into
// ID/EX, squashes the wrong-path fetch on taken branches and jumps, drives the
// EX-stage operand forwarding selects, and counts stalled cycles.
//
// Configuration macro: FORWARDING_EN
//   defined   : only a load in EX can stall ID (one-cycle load-use stall);
//               ForwardA/ForwardB select EX/MEM or MEM/WB results.
//   undefined : ID stalls while a pending writer sits in EX or MEM (the
//               register file is assumed to write in the first half-cycle, so
//               MEM/WB needs no stall); ForwardA/ForwardB are held at 00.
//
// Parameters
//   CNT_W          width of the saturating stall-cycle counter
//
// Ports
//   Clk            rising-edge clock
//   Reset          asynchronous active-high reset
//   IFID_Rs/Rt     source registers of the instruction in ID
//   IFID_UsesRt    ID instruction actually reads Rt
//   IDEX_Rs/Rt     source registers of the instruction in EX
//   IDEX_Rd        destination of the instruction in EX
//   IDEX_RegWrite  EX instruction writes IDEX_Rd
//   IDEX_MemRead   EX instruction is a load
//   EXMEM_Rd/RegWrite  destination / write enable of the instruction in MEM
//   MEMWB_Rd/RegWrite  destination / write enable of the instruction in WB
//   BranchTaken    branch resolved taken in EX
//   Jump           jump decoded in ID
//   PCWrite        PC load enable
//   IFIDWrite      IF/ID load enable
//   IFIDFlush      squash IF/ID contents
//   IDEXBubble     select for the ID/EX control-zeroing mux (1 = zero)
//   ForwardA/B     ALU operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   StallCycles    saturating count of cycles with PCWrite low
// -----------------------------------------------------------------------------
module ctrl_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic [4:0]       IDEX_Rs,
    input  logic [4:0]       IDEX_Rt,
    input  logic [4:0]       IDEX_Rd,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       EXMEM_Rd,
    input  logic             EXMEM_RegWrite,
    input  logic [4:0]       MEMWB_Rd,
    input  logic             MEMWB_RegWrite,
    input  logic             BranchTaken,
    input  logic             Jump,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Register x0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic f_match(input logic [4:0] a,
                                     input logic [4:0] b,
                                     input logic       we);
        return we && (a == b) && (a != 5'd0);
    endfunction

    // True when the ID instruction reads the given destination.
    function automatic logic f_id_reads(input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic       uses_rt,
                                        input logic [4:0] rd,
                                        input logic       we);
        return f_match(rs, rd, we) || (uses_rt && f_match(rt, rd, we));
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic w_dep_idex;
    logic w_dep_exmem;
    logic w_hazard_raw;
    logic w_hazard;

    assign w_dep_idex  = f_id_reads(IFID_Rs, IFID_Rt, IFID_UsesRt,
                                    IDEX_Rd, IDEX_RegWrite);
    assign w_dep_exmem = f_id_reads(IFID_Rs, IFID_Rt, IFID_UsesRt,
                                    EXMEM_Rd, EXMEM_RegWrite);

`ifdef FORWARDING_EN
    // Everything but a load result can be forwarded into EX in time.
    assign w_hazard_raw = w_dep_idex && IDEX_MemRead;

    logic w_unused_fwd;
    assign w_unused_fwd = w_dep_exmem;
`else
    // Without bypassing, ID must wait until the producer reaches writeback.
    assign w_hazard_raw = w_dep_idex || w_dep_exmem;

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{IDEX_Rs, IDEX_Rt, IDEX_MemRead,
                              MEMWB_Rd, MEMWB_RegWrite};
`endif

    // The ID slot following a flush holds a squashed instruction, so any
    // dependency it appears to have is spurious.
    assign w_hazard = w_hazard_raw && (r_state != ST_FLUSH);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // A taken branch wins over a hazard: the stalled instruction is on the
    // wrong path and is about to be squashed anyway.
    always_comb begin
        // NOTE: a default assignment ahead of the branches keeps this block
        // purely combinational; without it a missed path infers a latch.
        w_state_nxt = ST_RUN;
        if (BranchTaken) begin
            w_state_nxt = ST_FLUSH;
        end else if (w_hazard) begin
            w_state_nxt = ST_STALL;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    // Outputs react in the same cycle as the hazard/branch inputs. A jump
    // that meets a hazard waits: flushing IF/ID would lose the jump itself.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (w_hazard) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (Jump) begin
            IFIDFlush  = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding selects
    // -------------------------------------------------------------------------
`ifdef FORWARDING_EN
    // EX/MEM holds the younger result, so it takes priority on a double hit.
    always_comb begin
        ForwardA = FWD_REGFILE;
        ForwardB = FWD_REGFILE;
        if (!Reset) begin
            if (f_match(EXMEM_Rd, IDEX_Rs, EXMEM_RegWrite)) begin
                ForwardA = FWD_EXMEM;
            end else if (f_match(MEMWB_Rd, IDEX_Rs, MEMWB_RegWrite)) begin
                ForwardA = FWD_MEMWB;
            end
            if (f_match(EXMEM_Rd, IDEX_Rt, EXMEM_RegWrite)) begin
                ForwardB = FWD_EXMEM;
            end else if (f_match(MEMWB_Rd, IDEX_Rt, MEMWB_RegWrite)) begin
                ForwardB = FWD_MEMWB;
            end
        end
    end
`else
    assign ForwardA = FWD_REGFILE;
    assign ForwardB = FWD_REGFILE;

    logic [3:0] w_unused_fwd_sel;
    assign w_unused_fwd_sel = {FWD_MEMWB, FWD_EXMEM};
`endif

    // -------------------------------------------------------------------------
    // Stall-cycle performance counter (saturating)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign StallCycles = r_stall_cnt;

endmodule
